// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI mode controller: mode ids, FSM states, timing words and the mode table.
package hdmi_pkg;

  localparam int unsigned TW        = 12;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned NUM_MODES = 3;
  localparam int unsigned TO_W      = 20;

  typedef enum logic [MODE_W-1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1280X720 = 2'd2,
    MODE_INVALID  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_VS,
    ST_HOLD,
    ST_LOAD,
    ST_REL
  } state_t;

  typedef struct packed {
    logic [TW-1:0] h_total;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_start;
    logic [TW-1:0] h_end;
    logic [TW-1:0] v_total;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_start;
    logic [TW-1:0] v_end;
  } timing_t;

  localparam timing_t MODE0_T = '{h_total: 12'd799,  h_sync: 12'd95,  h_start: 12'd141,
                                  h_end:   12'd781,  v_total: 12'd524, v_sync: 12'd1,
                                  v_start: 12'd34,   v_end:   12'd514};
  localparam timing_t MODE1_T = '{h_total: 12'd1055, h_sync: 12'd127, h_start: 12'd213,
                                  h_end:   12'd1013, v_total: 12'd627, v_sync: 12'd3,
                                  v_start: 12'd26,   v_end:   12'd626};
  localparam timing_t MODE2_T = '{h_total: 12'd1649, h_sync: 12'd39,  h_start: 12'd257,
                                  h_end:   12'd1537, v_total: 12'd749, v_sync: 12'd4,
                                  v_start: 12'd24,   v_end:   12'd744};

  localparam timing_t [NUM_MODES-1:0] MODE_TABLE = {MODE2_T, MODE1_T, MODE0_T};

  // Invalid ids fall back to mode 0 so the lookup is total.
  function automatic timing_t mode_timing(input logic [MODE_W-1:0] id);
    timing_t t;
    case (id)
      2'd1:    t = MODE_TABLE[1];
      2'd2:    t = MODE_TABLE[2];
      default: t = MODE_TABLE[0];
    endcase
    return t;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector; the history flop resets high so a level already high at reset is not an edge.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b1;
    else       d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/hdmi_mode_ctrl.sv
// Video-mode controller: holds the timing table and switches hdmi_tx between modes at a frame
// boundary, keeping hdmi_tx in reset across the switch.
module hdmi_mode_ctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned VS_TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_req_valid,
  input  logic [MODE_W-1:0] mode_req_id,
  output logic              mode_req_ready,
  input  logic              vga_vs,
  output logic              tx_reset_n,
  output logic [TW-1:0]     h_total,
  output logic [TW-1:0]     h_sync,
  output logic [TW-1:0]     h_start,
  output logic [TW-1:0]     h_end,
  output logic [TW-1:0]     v_total,
  output logic [TW-1:0]     v_sync,
  output logic [TW-1:0]     v_start,
  output logic [TW-1:0]     v_end,
  output logic [MODE_W-1:0] cur_mode,
  output logic              switching,
  output logic              mode_done,
  output logic              mode_err
);

  localparam int unsigned     HCW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [MODE_W-1:0] DEF_ID  = MODE_W'(DEFAULT_MODE);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(VS_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX    = '1;

  state_t          state_q, state_d;
  logic [HCW-1:0]  hold_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            init_q;
  mode_t           req_id_q;
  timing_t         timing_q;
  logic            vs_rise_c;
  logic            accept_c;
  logic            done_d, err_d, tx_reset_n_d, ready_d, switching_d;

  edge_det u_vs_edge (
    .clk    (clk),
    .reset  (reset),
    .d      (vga_vs),
    .rise_c (vs_rise_c)
  );

  assign accept_c = mode_req_valid && (state_q == ST_RUN);

  // Next state plus the values the registered outputs take in that state.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept_c) begin
          if (mode_req_id == MODE_INVALID) err_d = 1'b1;
          else if (mode_req_id == cur_mode) done_d = 1'b1;
          else state_d = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: if (vs_rise_c || (to_cnt_q >= TO_LAST)) state_d = ST_HOLD;
      ST_HOLD:    if (hold_cnt_q >= HOLD_LAST) state_d = init_q ? ST_RUN : ST_LOAD;
      ST_LOAD:    state_d = ST_REL;
      ST_REL:     state_d = ST_RUN;
      default:    state_d = ST_HOLD;
    endcase
    if (state_d == ST_REL) done_d = 1'b1;
    tx_reset_n_d = (state_d == ST_RUN) || (state_d == ST_WAIT_VS) || (state_d == ST_REL);
    ready_d      = (state_d == ST_RUN);
    switching_d  = (state_d == ST_WAIT_VS) || (state_d == ST_HOLD) || (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_HOLD;
      init_q         <= 1'b1;
      hold_cnt_q     <= '0;
      to_cnt_q       <= '0;
      req_id_q       <= mode_t'(DEF_ID);
      cur_mode       <= DEF_ID;
      timing_q       <= mode_timing(DEF_ID);
      tx_reset_n     <= 1'b0;
      mode_req_ready <= 1'b0;
      switching      <= 1'b1;
      mode_done      <= 1'b0;
      mode_err       <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_reset_n     <= tx_reset_n_d;
      mode_req_ready <= ready_d;
      switching      <= switching_d;
      mode_done      <= done_d;
      mode_err       <= err_d;
      // Both counters restart on every state change; the timeout saturates instead of wrapping.
      if (state_d != state_q) begin
        hold_cnt_q <= '0;
        to_cnt_q   <= '0;
      end else begin
        if (state_q == ST_HOLD) hold_cnt_q <= hold_cnt_q + HCW'(1);
        if ((state_q == ST_WAIT_VS) && (to_cnt_q != TO_MAX)) to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (state_d == ST_RUN) init_q <= 1'b0;
      if (accept_c && (state_d == ST_WAIT_VS)) req_id_q <= mode_t'(mode_req_id);
      if (state_d == ST_LOAD) begin
        timing_q <= mode_timing(req_id_q);
        cur_mode <= req_id_q;
      end
    end
  end

  assign h_total = timing_q.h_total;
  assign h_sync  = timing_q.h_sync;
  assign h_start = timing_q.h_start;
  assign h_end   = timing_q.h_end;
  assign v_total = timing_q.v_total;
  assign v_sync  = timing_q.v_sync;
  assign v_start = timing_q.v_start;
  assign v_end   = timing_q.v_end;

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Scoreboard bench for hdmi_mode_ctrl: stimulus queues expected events, a monitor checks them.
module tb_hdmi_mode_ctrl;

  localparam int HOLD    = 16;
  localparam int VS_TO   = 100;
  localparam int LOW_LEN = HOLD + 1;
  localparam int K_SW    = 1;
  localparam int K_NOOP  = 2;
  localparam int K_ERR   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode_req_valid = 1'b0;
  logic [1:0]  mode_req_id = 2'd0;
  logic        mode_req_ready;
  logic        vga_vs = 1'b0;
  logic        tx_reset_n;
  logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
  logic [1:0]  cur_mode;
  logic        switching, mode_done, mode_err;

  hdmi_mode_ctrl #(.DEFAULT_MODE(0), .HOLD_CYCLES(HOLD), .VS_TIMEOUT(VS_TO)) dut (
    .clk(clk), .reset(reset), .mode_req_valid(mode_req_valid), .mode_req_id(mode_req_id),
    .mode_req_ready(mode_req_ready), .vga_vs(vga_vs), .tx_reset_n(tx_reset_n),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .cur_mode(cur_mode), .switching(switching), .mode_done(mode_done), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int TAB [3][8] = '{'{799, 95, 141, 781, 524, 1, 34, 514},
                     '{1055, 127, 213, 1013, 627, 3, 26, 626},
                     '{1649, 39, 257, 1537, 749, 4, 24, 744}};

  typedef struct {
    int kind;
    int mode;
    int acc_cyc;
    int low_start;
    int low_len;
    int evt_cyc;
  } exp_t;

  exp_t exp_q[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int dut_word(int i);
    case (i)
      0: return int'(h_total);
      1: return int'(h_sync);
      2: return int'(h_start);
      3: return int'(h_end);
      4: return int'(v_total);
      5: return int'(v_sync);
      6: return int'(v_start);
      default: return int'(v_end);
    endcase
  endfunction

  function automatic void chk_words(string tag, int mode);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_word%0d", tag, i), dut_word(i), TAB[mode][i]);
  endfunction

  function automatic void expect_evt(int kind, int mode, int acc, int low_start, int evt);
    exp_t e;
    e.kind = kind; e.mode = mode; e.acc_cyc = acc;
    e.low_start = low_start; e.low_len = (kind == K_SW) ? LOW_LEN : 0; e.evt_cyc = evt;
    exp_q.push_back(e);
  endfunction

  // Monitor: tracks tx_reset_n low runs and checks every done/err pulse against the queue.
  int last_low_cyc = -1;
  int run_start = -1;
  int run_len = 0;
  bit prev_tx = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (!tx_reset_n) begin
      last_low_cyc = cyc;
      if (prev_tx) begin
        run_start = cyc;
        run_len = 0;
      end
      run_len++;
    end
    prev_tx = tx_reset_n;
    if (!reset && (mode_done || mode_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d, none expected",
                 mode_done, mode_err, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("evt_cycle", cyc, e.evt_cyc);
        chk("evt_done", int'(mode_done), (e.kind != K_ERR) ? 1 : 0);
        chk("evt_err", int'(mode_err), (e.kind == K_ERR) ? 1 : 0);
        chk("evt_cur_mode", int'(cur_mode), e.mode);
        chk("evt_switching", int'(switching), 0);
        chk_words("evt", e.mode);
        if (e.kind == K_SW) begin
          chk("evt_low_start", run_start, e.low_start);
          chk("evt_low_len", run_len, e.low_len);
        end else begin
          chk("evt_no_reset_drop", (last_low_cyc < e.acc_cyc) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic request(input logic [1:0] id, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    mode_req_valid = 1'b1;
    mode_req_id = id;
    while (!mode_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", int'(mode_req_ready), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    mode_req_valid = 1'b0;
  endtask

  // Applies a one-cycle reset and checks the registered reset values and the init hold.
  task automatic pulse_reset();
    int r;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    r = cyc;
    @(negedge clk);
    chk("rst_tx_reset_n", int'(tx_reset_n), 0);
    chk("rst_ready", int'(mode_req_ready), 0);
    chk("rst_switching", int'(switching), 1);
    chk("rst_done", int'(mode_done), 0);
    chk("rst_err", int'(mode_err), 0);
    chk("rst_cur_mode", int'(cur_mode), 0);
    chk_words("rst", 0);
    reset = 1'b0;
    while (!tx_reset_n && cyc < r + 100) @(negedge clk);
    chk("init_low_cycles", cyc - r, HOLD);
    chk("init_ready", int'(mode_req_ready), 1);
    chk("init_switching", int'(switching), 0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int a;
    repeat (2) @(posedge clk);
    pulse_reset();

    // no-op request for the current mode
    request(2'd0, a);
    expect_evt(K_NOOP, 0, a, -1, a);
    @(negedge clk);
    chk("noop_ready", int'(mode_req_ready), 1);
    wait_cyc(a + 3);
    chk("noop_tx_high", int'(tx_reset_n), 1);
    drain(20);

    // invalid id
    request(2'd3, a);
    expect_evt(K_ERR, 0, a, -1, a);
    drain(20);

    // 0 -> 1 on a vsync edge 50 cycles after accept
    request(2'd1, a);
    expect_evt(K_SW, 1, a, a + 50, a + 50 + LOW_LEN);
    wait_cyc(a + 49);
    vga_vs = 1'b1;
    wait_cyc(a + 65);
    chk("pre_load_h_total", int'(h_total), 799);
    wait_cyc(a + 66);
    chk("load_h_total", int'(h_total), 1055);
    chk("load_cur_mode", int'(cur_mode), 1);
    chk("load_tx_low", int'(tx_reset_n), 0);
    drain(200);
    @(negedge clk);
    vga_vs = 1'b0;

    // 1 -> 2 with no vsync: timeout forces the switch
    request(2'd2, a);
    expect_evt(K_SW, 2, a, a + VS_TO, a + VS_TO + LOW_LEN);
    drain(300);

    // 2 -> 0, then abort a 0 -> 2 switch with reset in the middle of the hold
    request(2'd0, a);
    expect_evt(K_SW, 0, a, a + VS_TO, a + VS_TO + LOW_LEN);
    drain(300);
    request(2'd2, a);
    wait_cyc(a + VS_TO + 5);
    chk("abort_in_hold", int'(tx_reset_n), 0);
    pulse_reset();

    // request during WAIT_VS is ignored
    request(2'd1, a);
    expect_evt(K_SW, 1, a, a + 30, a + 30 + LOW_LEN);
    wait_cyc(a + 5);
    mode_req_valid = 1'b1;
    mode_req_id = 2'd2;
    chk("wait_vs_ready", int'(mode_req_ready), 0);
    wait_cyc(a + 20);
    mode_req_valid = 1'b0;
    wait_cyc(a + 29);
    vga_vs = 1'b1;
    drain(200);
    repeat (150) @(negedge clk);
    chk("final_cur_mode", int'(cur_mode), 1);
    chk("final_h_total", int'(h_total), 1055);
    chk("final_tx_high", int'(tx_reset_n), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
